mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {FETCH, DATA} owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational tie-break: a lone requester wins; on a tie the port that
// did not win last time is picked.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_t last_gnt,
  output logic   gnt_valid,
  output owner_t gnt_owner
);

  always_comb begin
    gnt_valid = if_req | d_req;
    gnt_owner = FETCH;
    if (if_req && d_req) begin
      gnt_owner = (last_gnt == FETCH) ? DATA : FETCH;
    end else if (d_req) begin
      gnt_owner = DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one fixed-latency memory port.
// state | meaning
// IDLE  | waiting for a request; grant is taken here
// BUSY  | memory access in flight, counter runs down to 0
// RESP  | owner's ack pulses for one cycle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_t             state_q, state_d;
  owner_t             owner_q, last_gnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        addr_q, wdata_q, if_rdata_q, d_rdata_q;
  logic               we_q;
  logic               gnt_valid;
  owner_t             gnt_owner;

  mem_arb_pick u_pick (
    .if_req    (if_req),
    .d_req     (d_req),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy   = (state_q != IDLE);
    mem_en = (state_q == BUSY);
    // Counter still holds its load value only in the first BUSY cycle
    mem_we = (state_q == BUSY) && we_q && (cnt_q == LAT_M1);
    if_ack = (state_q == RESP) && (owner_q == FETCH);
    d_ack  = (state_q == RESP) && (owner_q == DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= FETCH;
      last_gnt_q <= DATA;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state_q == IDLE && gnt_valid) begin
        owner_q    <= gnt_owner;
        last_gnt_q <= gnt_owner;
        cnt_q      <= LAT_M1;
        if (gnt_owner == FETCH) begin
          addr_q  <= if_addr;
          wdata_q <= '0;
          we_q    <= 1'b0;
        end else begin
          addr_q  <= d_addr;
          wdata_q <= d_wdata;
          we_q    <= d_we;
        end
      end else if (state_q == BUSY) begin
        if (cnt_q == '0) begin
          if (owner_q == FETCH) if_rdata_q <= mem_rdata;
          else                  d_rdata_q  <= we_q ? 32'h0 : mem_rdata;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; a second instance covers MEM_LAT=1.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;

  logic        if_ack, d_ack, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack1, d_ack1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata), .busy(busy1)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; drive and sample 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset values
    tick();
    chk_val("rst_mem_en", mem_en, 0);
    chk_val("rst_mem_we", mem_we, 0);
    chk_val("rst_mem_addr", mem_addr, 0);
    chk_val("rst_mem_wdata", mem_wdata, 0);
    chk_val("rst_acks", {if_ack, d_ack}, 0);
    chk_val("rst_if_rdata", if_rdata, 0);
    chk_val("rst_d_rdata", d_rdata, 0);
    chk_val("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // fetch only
    if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h00500093;
    chk_val("f_t0_busy", busy, 0);
    tick();
    chk_val("f_t1_en", mem_en, 1);
    chk_val("f_t1_addr", mem_addr, 32'h10);
    chk_val("f_t1_we", mem_we, 0);
    chk_val("f_t1_busy", busy, 1);
    chk_val("f_t1_ack", if_ack, 0);
    tick();
    chk_val("f_t2_en", mem_en, 1);
    chk_val("f_t2_addr", mem_addr, 32'h10);
    tick();
    chk_val("f_t3_en", mem_en, 0);
    chk_val("f_t3_ack", if_ack, 1);
    chk_val("f_t3_dack", d_ack, 0);
    chk_val("f_t3_rdata", if_rdata, 32'h00500093);
    if_req = 1'b0;
    tick();
    chk_val("f_t4_ack", if_ack, 0);
    chk_val("f_t4_busy", busy, 0);
    chk_val("f_t4_hold", if_rdata, 32'h00500093);

    // tie after reset: fetch first, then data
    do_reset();
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    mem_rdata = 32'h11112222;
    tick();
    chk_val("tie_t1_addr", mem_addr, 32'h20);
    tick();
    tick();
    chk_val("tie_t3_iack", if_ack, 1);
    chk_val("tie_t3_dack", d_ack, 0);
    chk_val("tie_t3_rdata", if_rdata, 32'h11112222);
    if_req = 1'b0; mem_rdata = 32'h33334444;
    tick();
    chk_val("tie_t4_busy", busy, 0);
    tick();
    chk_val("tie_t5_en", mem_en, 1);
    chk_val("tie_t5_addr", mem_addr, 32'h80);
    tick();
    chk_val("tie_t6_en", mem_en, 1);
    tick();
    chk_val("tie_t7_dack", d_ack, 1);
    chk_val("tie_t7_iack", if_ack, 0);
    chk_val("tie_t7_rdata", d_rdata, 32'h33334444);
    d_req = 1'b0;
    tick();

    // store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    tick();
    chk_val("st_t1_we", mem_we, 1);
    chk_val("st_t1_addr", mem_addr, 32'h40);
    chk_val("st_t1_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk_val("st_t2_we", mem_we, 0);
    chk_val("st_t2_en", mem_en, 1);
    chk_val("st_t2_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk_val("st_t3_dack", d_ack, 1);
    chk_val("st_t3_rdata", d_rdata, 0);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // both held: F,D,F,D,F with acks every 4 cycles (last grant was DATA)
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_addr = 32'h200;
    for (int k = 1; k <= 20; k++) begin
      logic fturn;
      tick();
      fturn = ((k / 4) % 2) == 0;
      chk_val($sformatf("alt_iack_%0d", k), if_ack, (k % 4 == 3) && fturn);
      chk_val($sformatf("alt_dack_%0d", k), d_ack, (k % 4 == 3) && !fturn);
      if (k % 4 == 1 || k % 4 == 2)
        chk_val($sformatf("alt_addr_%0d", k), mem_addr, fturn ? 32'h100 : 32'h200);
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // reset during BUSY aborts; held request restarts
    if_req = 1'b1; if_addr = 32'h30;
    tick();
    chk_val("ra_t1_en", mem_en, 1);
    tick();
    rst = 1'b1;
    #1;
    chk_val("ra_en", mem_en, 0);
    chk_val("ra_busy", busy, 0);
    chk_val("ra_addr", mem_addr, 0);
    chk_val("ra_ack", if_ack, 0);
    tick();
    chk_val("ra_t3_ack", if_ack, 0);
    rst = 1'b0;
    tick();
    chk_val("ra_r1_en", mem_en, 1);
    chk_val("ra_r1_addr", mem_addr, 32'h30);
    tick();
    chk_val("ra_r2_ack", if_ack, 0);
    tick();
    chk_val("ra_r3_ack", if_ack, 1);
    if_req = 1'b0;
    tick();

    // MEM_LAT=1 on dut1; dut sees the request drop mid-BUSY
    do_reset();
    if_req = 1'b1; if_addr = 32'h44; mem_rdata = 32'hCAFE0001;
    tick();
    chk_val("l1_t1_en", mem_en1, 1);
    chk_val("l1_t1_addr", mem_addr1, 32'h44);
    chk_val("l1_t1_ack", if_ack1, 0);
    tick();
    chk_val("l1_t2_en", mem_en1, 0);
    chk_val("l1_t2_ack", if_ack1, 1);
    chk_val("l1_t2_rdata", if_rdata1, 32'hCAFE0001);
    if_req = 1'b0;
    tick();
    chk_val("l1_t3_ack", if_ack1, 0);
    chk_val("drop_t3_ack", if_ack, 1);
    chk_val("drop_t3_rdata", if_rdata, 32'hCAFE0001);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
